// File: rtl/mem_port_arbiter.sv
// Two-client arbiter in front of a simple dual-port RAM with registered read.
// Write and read ports are arbitrated independently, round-robin on contention.
module mem_port_arbiter #(
  parameter int WIDTH  = 8,
  parameter int SIZE_E = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [SIZE_E-1:0] A_ADDR,
  input  logic [WIDTH-1:0]  A_WDATA,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic [WIDTH-1:0]  A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [SIZE_E-1:0] B_ADDR,
  input  logic [WIDTH-1:0]  B_WDATA,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic [WIDTH-1:0]  B_RDATA,
  output logic              MEM_WRITE,
  output logic              MEM_READ,
  output logic [SIZE_E-1:0] MEM_WRADDR,
  output logic [SIZE_E-1:0] MEM_RDADDR,
  output logic [WIDTH-1:0]  MEM_D,
  input  logic [WIDTH-1:0]  MEM_Q
);

  // bit 0 = client A, bit 1 = client B
  logic [1:0] req_wr;
  logic [1:0] req_rd;
  logic [1:0] gnt_wr;
  logic [1:0] gnt_rd;
  logic [1:0] ret_hit;

  logic wr_pri_reg, wr_pri_next;
  logic rd_pri_reg, rd_pri_next;
  logic rd_vld_reg, rd_vld_next;
  logic rd_own_reg, rd_own_next;

  assign req_wr = {B_REQ & B_WE,  A_REQ & A_WE};
  assign req_rd = {B_REQ & ~B_WE, A_REQ & ~A_WE};

  always_comb begin
    gnt_wr = 2'b00;
    gnt_rd = 2'b00;
    if (RSTN) begin
      if (&req_wr) gnt_wr = wr_pri_reg ? 2'b10 : 2'b01;
      else         gnt_wr = req_wr;
      if (&req_rd) gnt_rd = rd_pri_reg ? 2'b10 : 2'b01;
      else         gnt_rd = req_rd;
    end
  end

  // A flag only moves when both clients fight for its port
  always_comb begin
    wr_pri_next = wr_pri_reg ^ (&req_wr);
    rd_pri_next = rd_pri_reg ^ (&req_rd);
    rd_vld_next = |gnt_rd;
    rd_own_next = gnt_rd[1];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_pri_reg <= 1'b0;
      rd_pri_reg <= 1'b0;
      rd_vld_reg <= 1'b0;
      rd_own_reg <= 1'b0;
    end else begin
      wr_pri_reg <= wr_pri_next;
      rd_pri_reg <= rd_pri_next;
      rd_vld_reg <= rd_vld_next;
      rd_own_reg <= rd_own_next;
    end
  end

  assign A_GNT = gnt_wr[0] | gnt_rd[0];
  assign B_GNT = gnt_wr[1] | gnt_rd[1];

  always_comb begin
    MEM_WRITE  = |gnt_wr;
    MEM_READ   = |gnt_rd;
    MEM_WRADDR = '0;
    MEM_D      = '0;
    MEM_RDADDR = '0;
    if (gnt_wr[0]) begin
      MEM_WRADDR = A_ADDR;
      MEM_D      = A_WDATA;
    end else if (gnt_wr[1]) begin
      MEM_WRADDR = B_ADDR;
      MEM_D      = B_WDATA;
    end
    if (gnt_rd[0])      MEM_RDADDR = A_ADDR;
    else if (gnt_rd[1]) MEM_RDADDR = B_ADDR;
  end

  // Second return stage: RAM output is valid now, steer it to the read's owner
  assign ret_hit = {rd_vld_reg & rd_own_reg, rd_vld_reg & ~rd_own_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic             rvalid_reg;
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= ret_hit[gi];
        if (ret_hit[gi]) rdata_reg <= MEM_Q;
      end
    end
  end

  assign A_RVALID = g_ret[0].rvalid_reg;
  assign A_RDATA  = g_ret[0].rdata_reg;
  assign B_RVALID = g_ret[1].rvalid_reg;
  assign B_RDATA  = g_ret[1].rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read RAM.
module tb_mem_port_arbiter;

  logic       CLK;
  logic       RSTN;
  logic       A_REQ, A_WE, A_GNT, A_RVALID;
  logic [5:0] A_ADDR;
  logic [7:0] A_WDATA, A_RDATA;
  logic       B_REQ, B_WE, B_GNT, B_RVALID;
  logic [5:0] B_ADDR;
  logic [7:0] B_WDATA, B_RDATA;
  logic       MEM_WRITE, MEM_READ;
  logic [5:0] MEM_WRADDR, MEM_RDADDR;
  logic [7:0] MEM_D, MEM_Q;

  int errors;
  int checks;
  logic [7:0] ram [64];
  logic [7:0] t6_exp [4];

  mem_port_arbiter #(.WIDTH(8), .SIZE_E(6)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .MEM_WRADDR(MEM_WRADDR), .MEM_RDADDR(MEM_RDADDR),
    .MEM_D(MEM_D), .MEM_Q(MEM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // old word is returned on a same-address write/read because of the NBA ordering
  always @(posedge CLK) begin
    if (MEM_WRITE) ram[MEM_WRADDR] <= MEM_D;
    if (MEM_READ)  MEM_Q <= ram[MEM_RDADDR];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_WDATA = '0;
  endtask

  task automatic do_reset;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    RSTN = 1'b0;

    // reset: grants forced low even with a request present
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 6'd5; A_WDATA = 8'h3C;
    #1;
    chk("rst_a_gnt", A_GNT, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    tick(); tick();
    chk("rst_a_rvalid", A_RVALID, 0);
    chk("rst_b_rvalid", B_RVALID, 0);
    chk("rst_a_rdata", A_RDATA, 0);
    chk("rst_b_rdata", B_RDATA, 0);
    RSTN = 1'b1;
    #1;

    // T1: A write 5 = 3C, then A read 5
    chk("t1_wr_gnt", A_GNT, 1);
    chk("t1_mem_write", MEM_WRITE, 1);
    chk("t1_mem_wraddr", MEM_WRADDR, 5);
    chk("t1_mem_d", MEM_D, 8'h3C);
    chk("t1_mem_read_idle", MEM_READ, 0);
    tick();
    A_WE = 1'b0;
    #1;
    chk("t1_rd_gnt", A_GNT, 1);
    chk("t1_mem_read", MEM_READ, 1);
    chk("t1_mem_rdaddr", MEM_RDADDR, 5);
    chk("t1_mem_write_idle", MEM_WRITE, 0);
    chk("t1_mem_wraddr_zero", MEM_WRADDR, 0);
    tick();
    idle();
    chk("t1_rvalid_early", A_RVALID, 0);
    tick();
    chk("t1_rvalid", A_RVALID, 1);
    chk("t1_rdata", A_RDATA, 8'h3C);
    chk("t1_b_rvalid", B_RVALID, 0);
    tick();
    chk("t1_rvalid_once", A_RVALID, 0);
    chk("t1_rdata_hold", A_RDATA, 8'h3C);

    // T2: contended writes, then contended reads
    do_reset();
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 6'd1; A_WDATA = 8'h11;
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 6'd2; B_WDATA = 8'h22;
    #1;
    chk("t2_c0_a_gnt", A_GNT, 1);
    chk("t2_c0_b_gnt", B_GNT, 0);
    chk("t2_c0_wraddr", MEM_WRADDR, 1);
    tick();
    chk("t2_c1_a_gnt", A_GNT, 0);
    chk("t2_c1_b_gnt", B_GNT, 1);
    chk("t2_c1_mem_d", MEM_D, 8'h22);
    tick();
    idle();
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 6'd1;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'd2;
    #1;
    chk("t2_r0_a_gnt", A_GNT, 1);
    chk("t2_r0_b_gnt", B_GNT, 0);
    tick();
    A_REQ = 1'b0;
    #1;
    chk("t2_r1_b_gnt", B_GNT, 1);
    tick();
    idle();
    chk("t2_a_rvalid", A_RVALID, 1);
    chk("t2_a_rdata", A_RDATA, 8'h11);
    chk("t2_b_rvalid_early", B_RVALID, 0);
    tick();
    chk("t2_b_rvalid", B_RVALID, 1);
    chk("t2_b_rdata", B_RDATA, 8'h22);
    chk("t2_a_rvalid_once", A_RVALID, 0);

    // T3: write and read of the same address in one cycle
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 6'd7; A_WDATA = 8'h55;
    #1;
    chk("t3_pre_gnt", A_GNT, 1);
    tick();
    A_WDATA = 8'hAA;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'd7;
    #1;
    chk("t3_a_gnt", A_GNT, 1);
    chk("t3_b_gnt", B_GNT, 1);
    chk("t3_mem_write", MEM_WRITE, 1);
    chk("t3_mem_read", MEM_READ, 1);
    tick();
    idle();
    tick();
    chk("t3_b_rvalid", B_RVALID, 1);
    chk("t3_b_rdata_old", B_RDATA, 8'h55);
    chk("t3_a_rvalid", A_RVALID, 0);
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'd7;
    #1;
    chk("t3_reread_gnt", B_GNT, 1);
    tick();
    idle();
    tick();
    chk("t3_reread_rvalid", B_RVALID, 1);
    chk("t3_b_rdata_new", B_RDATA, 8'hAA);

    // T4: preload 10..12 and 20..22, then continuous contended reads
    for (int i = 0; i < 6; i++) begin
      A_REQ = 1'b1; A_WE = 1'b1;
      A_ADDR  = (i < 3) ? 6'(10 + i) : 6'(17 + i);
      A_WDATA = (i < 3) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 3);
      #1;
      chk($sformatf("t4_prep%0d_gnt", i), A_GNT, 1);
      tick();
    end
    idle();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 6'(10 + (c + 1) / 2);
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'(20 + c / 2);
      end else begin
        idle();
      end
      #1;
      if (c < 6) begin
        chk($sformatf("t4_c%0d_a_gnt", c), A_GNT, 32'(c % 2 == 0));
        chk($sformatf("t4_c%0d_b_gnt", c), B_GNT, 32'(c % 2 == 1));
      end
      if (c >= 2) begin
        if ((c - 2) % 2 == 0) begin
          chk($sformatf("t4_c%0d_a_rvalid", c), A_RVALID, 1);
          chk($sformatf("t4_c%0d_a_rdata", c), A_RDATA, 32'(8'hA0 + (c - 2) / 2));
          chk($sformatf("t4_c%0d_b_rvalid", c), B_RVALID, 0);
        end else begin
          chk($sformatf("t4_c%0d_b_rvalid", c), B_RVALID, 1);
          chk($sformatf("t4_c%0d_b_rdata", c), B_RDATA, 32'(8'hB0 + (c - 2) / 2));
          chk($sformatf("t4_c%0d_a_rvalid", c), A_RVALID, 0);
        end
      end else begin
        chk($sformatf("t4_c%0d_a_rvalid", c), A_RVALID, 0);
        chk($sformatf("t4_c%0d_b_rvalid", c), B_RVALID, 0);
      end
      tick();
    end

    // T5: reset right after a read grant drops it and restores A-first
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 6'd5;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'd6;
    #1;
    chk("t5_a_gnt", A_GNT, 1);
    chk("t5_b_gnt", B_GNT, 0);
    tick();
    RSTN = 1'b0;
    #1;
    chk("t5_rst_a_gnt", A_GNT, 0);
    chk("t5_rst_b_gnt", B_GNT, 0);
    chk("t5_rst_mem_read", MEM_READ, 0);
    tick();
    RSTN = 1'b1;
    #1;
    chk("t5_dropped_rvalid", A_RVALID, 0);
    chk("t5_rdata_cleared", A_RDATA, 0);
    chk("t5_pri_a_gnt", A_GNT, 1);
    chk("t5_pri_b_gnt", B_GNT, 0);
    tick();
    idle();
    chk("t5_rvalid_late", A_RVALID, 0);
    tick();
    chk("t5_new_rvalid", A_RVALID, 1);
    chk("t5_new_rdata", A_RDATA, 8'h3C);
    tick();
    chk("t5_new_rvalid_once", A_RVALID, 0);

    // T6: single requester B reads 0..3 back to back
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 6'd0; B_WDATA = 8'hC0;
    #1;
    chk("t6_prep0_gnt", B_GNT, 1);
    tick();
    B_ADDR = 6'd3; B_WDATA = 8'hC3;
    #1;
    chk("t6_prep3_gnt", B_GNT, 1);
    tick();
    idle();
    t6_exp[0] = 8'hC0; t6_exp[1] = 8'h11; t6_exp[2] = 8'h22; t6_exp[3] = 8'hC3;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 6'(c);
      end else begin
        idle();
      end
      #1;
      if (c < 4) chk($sformatf("t6_c%0d_b_gnt", c), B_GNT, 1);
      if (c >= 2 && c < 6) begin
        chk($sformatf("t6_c%0d_b_rvalid", c), B_RVALID, 1);
        chk($sformatf("t6_c%0d_b_rdata", c), B_RDATA, 32'(t6_exp[c - 2]));
      end else begin
        chk($sformatf("t6_c%0d_b_rvalid", c), B_RVALID, 0);
      end
      chk($sformatf("t6_c%0d_a_rvalid", c), A_RVALID, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
